data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 146 ++++++++++++++
 tb/tb_data_mem_resp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Single-port 64-bit data memory behind a valid/ready request port and a one-cycle response pulse.
// Each request walks IDLE -> ACCESS -> RESP; sub-word stores merge bytes, loads return the word shifted right by the byte offset.
module data_mem_resp #(
    parameter int unsigned DEPTH = 512,
    parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [63:0] Raddr,
    input  logic [63:0] Waddr,
    input  logic [63:0] WData,
    input  logic [3:0]  Wmask,
    output logic        RespValid,
    output logic [63:0] RespData,
    output logic        RespErr
);

    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    // Handshake: a request is taken on a Clk edge where ReqValid=1 and ReqReady=1;
    // ReqReady is high only in IDLE outside reset, RespValid only in RESP outside reset.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem_q [DEPTH];

    logic [2:0]      offset;
    logic [63:0]     diff;
    logic            out_of_range;
    logic [IDXW-1:0] idx;
    logic [7:0]      size_be;
    logic            mask_bad;
    logic            align_ok;
    logic            req_err;
    logic [7:0]      byte_en;
    logic [63:0]     wdata_sh;
    logic [63:0]     load_data;
    logic            mem_we;

    // Decode of the registered request, used only while in ACCESS.
    always_comb begin
        offset       = addr_q[2:0];
        diff         = addr_q - BASE;
        out_of_range = (addr_q < BASE) || (diff >= SPAN);
        idx          = diff[IDXW+2:3];
        size_be      = 8'h00;
        mask_bad     = 1'b0;
        align_ok     = 1'b1;
        case (wmask_q)
            4'b1000: begin size_be = 8'hFF; align_ok = (offset == 3'd0);      end
            4'b0100: begin size_be = 8'h0F; align_ok = (offset[1:0] == 2'd0); end
            4'b0010: begin size_be = 8'h03; align_ok = (offset[0] == 1'b0);   end
            4'b0001: begin size_be = 8'h01; align_ok = 1'b1;                  end
            default: begin mask_bad = 1'b1; end
        endcase
        req_err   = out_of_range || (write_q && (mask_bad || !align_ok));
        byte_en   = size_be << offset;
        wdata_sh  = wdata_q << {offset, 3'b000};
        load_data = mem_q[idx] >> {offset, 3'b000};
        mem_we    = (state_q == S_ACCESS) && write_q && !req_err && !Rst;
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    write_d = ReqWrite;
                    addr_d  = ReqWrite ? Waddr : Raddr;
                    wdata_d = WData;
                    wmask_d = Wmask;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                err_d   = req_err;
                rdata_d = (!write_q && !req_err) ? load_data : 64'd0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            wmask_q <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array is deliberately left out of reset; mem_we already carries reset priority.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign ReqReady  = (state_q == S_IDLE) && !Rst;
    assign RespValid = (state_q == S_RESP) && !Rst;
    assign RespData  = RespValid ? rdata_q : 64'd0;
    assign RespErr   = RespValid && err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: table of requests with hand-derived results, a response scoreboard,
// plus hand-written back-to-back and reset-during-store sequences.
module tb_data_mem_resp;

    logic        Clk;
    logic        Rst;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [63:0] Raddr;
    logic [63:0] Waddr;
    logic [63:0] WData;
    logic [3:0]  Wmask;
    logic        RespValid;
    logic [63:0] RespData;
    logic        RespErr;

    data_mem_resp dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .Raddr(Raddr), .Waddr(Waddr), .WData(WData), .Wmask(Wmask),
        .RespValid(RespValid), .RespData(RespData), .RespErr(RespErr)
    );

    typedef struct {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  wmask;
        logic        exp_err;
        logic [63:0] exp_data;
    } vec_t;

    vec_t        tbl[$];
    vec_t        burst[$];
    logic [64:0] exp_q[$];
    int          acc_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          resp_count = 0;
    int          last_acc = 0;
    logic [64:0] mon_e;
    int          mon_a;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic vec_t mk(logic w, logic [63:0] a, logic [63:0] d, logic [3:0] m,
                                logic e, logic [63:0] x);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = d; v.wmask = m; v.exp_err = e; v.exp_data = x;
        return v;
    endfunction

    // Scoreboard side: every response pulse is matched against the oldest expectation.
    always @(negedge Clk) begin
        if (RespValid) begin
            resp_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got data 0x%016h err %0b with nothing outstanding", RespData, RespErr);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                check("resp_data", RespData, mon_e[63:0]);
                check("resp_err", 64'(RespErr), 64'(mon_e[64]));
                check("resp_latency", 64'(cyc - mon_a), 64'd2);
            end
        end else if (!Rst) begin
            check("idle_resp_data_zero", RespData, 64'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the acceptance edge (ACCESS cycle).
    task automatic issue(input vec_t v, input bit hold, output int waited);
        ReqWrite = v.write;
        Raddr    = v.write ? {$urandom, $urandom} : v.addr;
        Waddr    = v.write ? v.addr : {$urandom, $urandom};
        WData    = v.wdata;
        Wmask    = v.wmask;
        ReqValid = 1'b1;
        waited   = 0;
        #1;
        while (!ReqReady && waited < 10) begin
            @(negedge Clk);
            #1;
            waited++;
        end
        check("req_accept", 64'(ReqReady), 64'd1);
        if (ReqReady) begin
            exp_q.push_back({v.exp_err, v.exp_data});
            acc_q.push_back(cyc);
            last_acc = cyc;
            @(negedge Clk);
            if (!hold) begin
                ReqValid = 1'b0;
                ReqWrite = $urandom_range(0, 1) == 1;
                Raddr    = {$urandom, $urandom};
                Waddr    = {$urandom, $urandom};
                WData    = {$urandom, $urandom};
                Wmask    = 4'($urandom_range(0, 15));
            end
        end else begin
            ReqValid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int prev;
        int rc0;

        // Stores and loads applied in order; expectations follow the array contents.
        tbl.push_back(mk(1, 64'h8000_0010, 64'h1122_3344_5566_7788, 4'b1000, 0, 64'h0));
        tbl.push_back(mk(0, 64'h8000_0010, 64'h0, 4'b1000, 0, 64'h1122_3344_5566_7788));
        tbl.push_back(mk(1, 64'h8000_0013, 64'hAB, 4'b0001, 0, 64'h0));
        tbl.push_back(mk(0, 64'h8000_0010, 64'h0, 4'b0000, 0, 64'h1122_3344_AB66_7788));
        tbl.push_back(mk(0, 64'h8000_0016, 64'h0, 4'b0001, 0, 64'h0000_0000_0000_1122));
        tbl.push_back(mk(1, 64'h8000_0012, 64'hFFFF_FFFF, 4'b0100, 1, 64'h0));
        tbl.push_back(mk(1, 64'h8000_0010, 64'hFFFF, 4'b0011, 1, 64'h0));
        tbl.push_back(mk(0, 64'h7FFF_FFF8, 64'h0, 4'b1000, 1, 64'h0));
        tbl.push_back(mk(0, 64'h8000_1000, 64'h0, 4'b1000, 1, 64'h0));
        tbl.push_back(mk(0, 64'h1_8000_0010, 64'h0, 4'b1000, 1, 64'h0));
        tbl.push_back(mk(1, 64'h8000_1000, 64'h55, 4'b1000, 1, 64'h0));
        tbl.push_back(mk(1, 64'h8000_0010, 64'h55, 4'b0000, 1, 64'h0));
        tbl.push_back(mk(0, 64'h8000_0010, 64'h0, 4'b1000, 0, 64'h1122_3344_AB66_7788));
        tbl.push_back(mk(1, 64'h8000_0FF8, 64'hCAFE_BABE_DEAD_BEEF, 4'b1000, 0, 64'h0));
        tbl.push_back(mk(0, 64'h8000_0FF8, 64'h0, 4'b1000, 0, 64'hCAFE_BABE_DEAD_BEEF));
        tbl.push_back(mk(1, 64'h8000_0FFC, 64'hFFFF_FFFF_1234_5678, 4'b0100, 0, 64'h0));
        tbl.push_back(mk(0, 64'h8000_0FF8, 64'h0, 4'b1000, 0, 64'h1234_5678_DEAD_BEEF));
        tbl.push_back(mk(0, 64'h8000_0FFD, 64'h0, 4'b1000, 0, 64'h0000_0000_0012_3456));
        tbl.push_back(mk(0, 64'h8000_0FFF, 64'h0, 4'b1000, 0, 64'h0000_0000_0000_0012));
        tbl.push_back(mk(1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 4'b1000, 0, 64'h0));
        tbl.push_back(mk(1, 64'h8000_0022, 64'hFFFF_BEEF, 4'b0010, 0, 64'h0));
        tbl.push_back(mk(0, 64'h8000_0020, 64'h0, 4'b1000, 0, 64'h0123_4567_BEEF_CDEF));
        tbl.push_back(mk(1, 64'h8000_0021, 64'h1111, 4'b0010, 1, 64'h0));
        tbl.push_back(mk(0, 64'h8000_0020, 64'h0, 4'b1000, 0, 64'h0123_4567_BEEF_CDEF));
        tbl.push_back(mk(0, 64'h8000_0013, 64'h0, 4'b0000, 0, 64'h0000_0011_2233_44AB));

        burst.push_back(mk(0, 64'h8000_0010, 64'h0, 4'b1000, 0, 64'h1122_3344_AB66_7788));
        burst.push_back(mk(0, 64'h8000_0FF8, 64'h0, 4'b1000, 0, 64'h1234_5678_DEAD_BEEF));
        burst.push_back(mk(0, 64'h8000_0020, 64'h0, 4'b1000, 0, 64'h0123_4567_BEEF_CDEF));
        burst.push_back(mk(0, 64'h8000_0014, 64'h0, 4'b1000, 0, 64'h0000_0000_1122_3344));

        // Reset
        Rst = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0;
        Raddr = 64'd0; Waddr = 64'd0; WData = 64'd0; Wmask = 4'd0;
        repeat (3) @(negedge Clk);
        check("rst_req_ready", 64'(ReqReady), 64'd0);
        check("rst_resp_valid", 64'(RespValid), 64'd0);
        check("rst_resp_err", 64'(RespErr), 64'd0);
        check("rst_resp_data", RespData, 64'd0);
        Rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(ReqReady), 64'd1);
        @(negedge Clk);

        // Table-driven requests
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i], 1'b0, w);
        end
        drain();

        // Back-to-back loads with ReqValid held high
        rc0  = resp_count;
        prev = 0;
        for (int i = 0; i < burst.size(); i++) begin
            issue(burst[i], i < burst.size() - 1, w);
            if (i > 0) begin
                check("b2b_ready_low_cycles", 64'(w), 64'd2);
                check("b2b_spacing", 64'(last_acc - prev), 64'd3);
            end
            prev = last_acc;
        end
        drain();
        check("b2b_resp_count", 64'(resp_count - rc0), 64'd4);

        // Reset asserted during the ACCESS cycle of a store
        ReqWrite = 1'b1; Waddr = 64'h8000_0020; WData = 64'hFF; Wmask = 4'b0001; ReqValid = 1'b1;
        #1;
        check("rst_store_ready", 64'(ReqReady), 64'd1);
        @(negedge Clk);
        Rst = 1'b1; ReqWrite = 1'b0; Raddr = 64'h8000_0010;
        #1;
        check("rst_hold_ready", 64'(ReqReady), 64'd0);
        @(negedge Clk);
        #1;
        check("rst_drop_valid", 64'(RespValid), 64'd0);
        check("rst_drop_data", RespData, 64'd0);
        @(negedge Clk);
        Rst = 1'b0; ReqValid = 1'b0;
        #1;
        check("ready_after_rst2", 64'(ReqReady), 64'd1);
        rc0 = resp_count;
        repeat (4) @(negedge Clk);
        check("no_resp_after_rst", 64'(resp_count - rc0), 64'd0);
        issue(mk(0, 64'h8000_0020, 64'h0, 4'b1000, 0, 64'h0123_4567_BEEF_CDEF), 1'b0, w);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
